// File: rtl/mem_stage.sv
// Memory-access pipeline stage: multi-cycle load/store to an internal word RAM,
// upstream stall generation and the MEM/WB pipeline register.
module mem_stage #(
  parameter int          DEPTH         = 64,
  parameter logic [31:0] ADDR_BASE     = 32'd1024,
  parameter int          ACCESS_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        wb_en_in,
  input  logic        mem_r_en,
  input  logic        mem_w_en,
  input  logic [31:0] alu_result,
  input  logic [31:0] st_val,
  input  logic [3:0]  dest,
  output logic        stall,
  output logic [31:0] pc_out,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] mem_data_out,
  output logic [3:0]  dest_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_reg;
  logic [CW-1:0]  cnt_reg;
  logic [31:0]    rd_buf_reg;
  logic [31:0]    mem [DEPTH];

  logic [AW-1:0]  idx;
  logic           request;
  logic           is_load;
  logic           last_beat;

  // Out-of-range addresses simply wrap onto the array; the byte offset is dropped.
  assign idx       = AW'((alu_result - ADDR_BASE) >> 2);
  assign request   = mem_r_en | mem_w_en;
  assign is_load   = mem_r_en & ~mem_w_en;
  assign last_beat = (state_reg == BUSY) && (cnt_reg == CNT_LAST);

  assign stall = ~rst & (((state_reg == IDLE) & request) | (state_reg == BUSY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      rd_buf_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (request) begin
            state_reg <= BUSY;
            cnt_reg   <= '0;
          end
        end
        BUSY: begin
          if (cnt_reg == CNT_LAST) begin
            state_reg <= DONE;
            if (!mem_w_en) begin
              rd_buf_reg <= mem[idx];
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Inputs are frozen upstream during the access, so only the final edge samples them.
  always_ff @(posedge clk) begin
    if (last_beat && mem_w_en) begin
      mem[idx] <= st_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_out         <= '0;
      wb_en_out      <= 1'b0;
      mem_r_en_out   <= 1'b0;
      alu_result_out <= '0;
      mem_data_out   <= '0;
      dest_out       <= '0;
    end else if (stall) begin
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
    end else begin
      pc_out         <= pc_in;
      wb_en_out      <= wb_en_in;
      mem_r_en_out   <= mem_r_en;
      alu_result_out <= alu_result;
      mem_data_out   <= is_load ? rd_buf_reg : 32'd0;
      dest_out       <= dest;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage: each instruction is checked against a
// word-array model of the data memory and the stall-length rule.
module tb_mem_stage;

  localparam int DEPTH = 64;
  localparam int AC    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        wb_en_in, mem_r_en, mem_w_en;
  logic [31:0] alu_result, st_val;
  logic [3:0]  dest;
  logic        stall;
  logic [31:0] pc_out;
  logic        wb_en_out, mem_r_en_out;
  logic [31:0] alu_result_out, mem_data_out;
  logic [3:0]  dest_out;

  mem_stage #(.DEPTH(DEPTH), .ADDR_BASE(32'd1024), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .wb_en_in(wb_en_in),
    .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .alu_result(alu_result),
    .st_val(st_val), .dest(dest), .stall(stall), .pc_out(pc_out),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
    .alu_result_out(alu_result_out), .mem_data_out(mem_data_out),
    .dest_out(dest_out)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit [31:0]   model_mem [DEPTH];
  bit [31:0]   prev_pc = 0;
  bit [31:0]   prev_alu = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int widx(input bit [31:0] addr);
    bit [31:0] off;
    off = addr - 32'd1024;
    return int'((off >> 2) % DEPTH);
  endfunction

  task automatic drive(input bit [31:0] pc, input bit wb, input bit r, input bit w,
                       input bit [31:0] alu, input bit [31:0] st, input bit [3:0] d);
    pc_in = pc; wb_en_in = wb; mem_r_en = r; mem_w_en = w;
    alu_result = alu; st_val = st; dest = d;
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that retires the instruction.
  task automatic issue(input bit [31:0] pc, input bit wb, input bit r, input bit w,
                       input bit [31:0] alu, input bit [31:0] st, input bit [3:0] d);
    int stalls;
    int exp_stalls;
    bit [31:0] exp_data;
    stalls = 0;
    exp_stalls = (r | w) ? AC + 1 : 0;
    drive(pc, wb, r, w, alu, st, d);
    @(negedge clk);
    while (stall === 1'b1 && stalls < 40) begin
      stalls++;
      @(posedge clk); #1;
      check("bubble_wb", {31'd0, wb_en_out}, 32'd0);
      check("bubble_rd", {31'd0, mem_r_en_out}, 32'd0);
      check("hold_pc", pc_out, prev_pc);
      check("hold_alu", alu_result_out, prev_alu);
      @(negedge clk);
    end
    check("stall_cycles", stalls, exp_stalls);
    exp_data = 32'd0;
    if (w) model_mem[widx(alu)] = st;
    else if (r) exp_data = model_mem[widx(alu)];
    @(posedge clk); #1;
    check("pc_out", pc_out, pc);
    check("wb_en_out", {31'd0, wb_en_out}, {31'd0, wb});
    check("mem_r_en_out", {31'd0, mem_r_en_out}, {31'd0, r});
    check("alu_result_out", alu_result_out, alu);
    check("mem_data_out", mem_data_out, exp_data);
    check("dest_out", {28'd0, dest_out}, {28'd0, d});
    $display("[TB] pc=%08h r=%0d w=%0d addr=%0d data=%08h stalls=%0d",
             pc, r, w, alu, mem_data_out, stalls);
    prev_pc = pc;
    prev_alu = alu;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_stall"}, {31'd0, stall}, 32'd0);
    check({tag, "_pc"}, pc_out, 32'd0);
    check({tag, "_wb"}, {31'd0, wb_en_out}, 32'd0);
    check({tag, "_rd"}, {31'd0, mem_r_en_out}, 32'd0);
    check({tag, "_alu"}, alu_result_out, 32'd0);
    check({tag, "_data"}, mem_data_out, 32'd0);
    check({tag, "_dest"}, {28'd0, dest_out}, 32'd0);
  endtask

  // Store interrupted by rst after 'edges' rising edges; commits only if DONE was reached.
  task automatic store_then_reset(input bit [31:0] addr, input bit [31:0] val, input int edges);
    drive(32'h0000_0F00, 1'b0, 1'b0, 1'b1, addr, val, 4'd0);
    repeat (edges) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("midrst");
    drive(32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    if (edges >= AC + 1) model_mem[widx(addr)] = val;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    prev_pc = 0;
    prev_alu = 0;
    @(posedge clk); #1;
    $display("[TB] store to %0d reset after %0d edges", addr, edges);
  endtask

  initial begin
    bit [31:0] pc;
    int kind;
    bit [31:0] addr;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
    rst = 1'b1;
    drive(32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    issue(32'h100, 1'b1, 1'b0, 1'b0, 32'h55, 32'd0, 4'd3);
    issue(32'h104, 1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 4'd0);
    issue(32'h108, 1'b1, 1'b1, 1'b0, 32'd1032, 32'd0, 4'd5);
    issue(32'h10C, 1'b0, 1'b0, 1'b1, 32'd1280, 32'h12345678, 4'd0);
    issue(32'h110, 1'b1, 1'b1, 1'b0, 32'd1024, 32'd0, 4'd6);
    issue(32'h114, 1'b1, 1'b1, 1'b0, 32'd1026, 32'd0, 4'd7);
    issue(32'h118, 1'b1, 1'b1, 1'b1, 32'd1040, 32'hA5A5A5A5, 4'd8);
    issue(32'h11C, 1'b1, 1'b1, 1'b0, 32'd1040, 32'd0, 4'd9);
    // Back-to-back ALU, store, ALU, load
    issue(32'h120, 1'b1, 1'b0, 1'b0, 32'h77, 32'd0, 4'd1);
    issue(32'h124, 1'b0, 1'b0, 1'b1, 32'd1100, 32'hCAFEF00D, 4'd0);
    issue(32'h128, 1'b1, 1'b0, 1'b0, 32'h88, 32'd0, 4'd2);
    issue(32'h12C, 1'b1, 1'b1, 1'b0, 32'd1100, 32'd0, 4'd4);

    // Store cut in its 3rd BUSY cycle must not land; one reset in DONE must.
    store_then_reset(32'd1200, 32'hBAD0BAD0, 3);
    issue(32'h200, 1'b1, 1'b1, 1'b0, 32'd1200, 32'd0, 4'd10);
    store_then_reset(32'd1204, 32'h600DF00D, AC + 1);
    issue(32'h204, 1'b1, 1'b1, 1'b0, 32'd1204, 32'd0, 4'd11);

    pc = 32'h1000;
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      addr = 32'd1024 + 4 * $urandom_range(0, 2 * DEPTH - 1) + $urandom_range(0, 3);
      if (kind < 3)
        issue(pc, 1'(kind != 0), 1'b0, 1'b0, $urandom, $urandom, 4'($urandom));
      else if (kind < 6)
        issue(pc, 1'b0, 1'b0, 1'b1, addr, $urandom, 4'($urandom));
      else if (kind < 9)
        issue(pc, 1'b1, 1'b1, 1'b0, addr, $urandom, 4'($urandom));
      else
        issue(pc, 1'b1, 1'b1, 1'b1, addr, $urandom, 4'($urandom));
      pc = pc + 32'd4;
    end

    // Assert rst mid-run with nonzero outputs, then an ALU op right after release.
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("runrst");
    drive(32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    prev_pc = 0;
    prev_alu = 0;
    @(posedge clk); #1;
    issue(32'h300, 1'b1, 1'b0, 1'b0, 32'h55, 32'd0, 4'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage pipeline. It sits directly downstream of the execute stage and its EX/MEM register. It performs load/store accesses to an internal word-addressed data memory that takes several cycles per access, stalls the upstream pipeline while an access is in flight, and drives the MEM/WB pipeline register that feeds write-back.

## Interface
Parameters:
- DEPTH, 64: number of 32-bit words in the data memory; must be a power of 2.
- ADDR_BASE, 1024: byte address that maps to word 0.
- ACCESS_CYCLES, 4: busy cycles per memory access; must be ≥1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- pc_in  in  32  PC of the instruction in MEM.
- wb_en_in  in  1  instruction writes a register.
- mem_r_en  in  1  load request.
- mem_w_en  in  1  store request.
- alu_result  in  32  byte address for loads and stores; the result value for ALU instructions.
- st_val  in  32  store data.
- dest  in  4  destination register.
- stall  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM while high.
- pc_out  out  32  registered PC to WB.
- wb_en_out  out  1  registered write enable to WB.
- mem_r_en_out  out  1  registered; selects mem_data_out in WB.
- alu_result_out  out  32  registered ALU result.
- mem_data_out  out  32  registered load data.
- dest_out  out  4  registered destination.

## Operation
- Word index = (alu_result − ADDR_BASE) >> 2, truncated to log2(DEPTH) bits. Out-of-range addresses alias and are not flagged. Byte offset bits [1:0] are ignored.
- The memory array is not cleared by rst. It is all-zero at simulation start.
- A request is mem_r_en | mem_w_en. If both are high, the access is a write and mem_data_out loads 0.
- FSM states:
  - IDLE:
    - With a request: go to BUSY and set cnt=0.
    - Without a request: stay in IDLE.
  - BUSY:
    - While cnt < ACCESS_CYCLES−1: increment cnt.
    - When cnt == ACCESS_CYCLES−1: go to DONE. On that same edge, perform the store (mem[idx] ← st_val), or latch the load data mem[idx] into an internal read buffer.
  - DONE: unconditionally return to IDLE.
- stall = (IDLE & request) | BUSY. stall is 0 in DONE.
- MEM/WB register update rule:
  - When stall=0: load all outputs from the inputs. mem_data_out takes the read buffer for a load, and 0 otherwise.
  - When stall=1: load a bubble (wb_en_out=0, mem_r_en_out=0). All other outputs hold their values.
- While stall=1, all inputs are held stable by the frozen EX/MEM register. The block relies on this and samples alu_result and st_val only on the final BUSY edge.
- Non-memory instructions never stall and pass through in 1 cycle.

## Timing
- Reset values: all outputs 0, state IDLE, cnt 0, read buffer 0. stall is 0 while no request is present.
- Latency with no memory access: outputs are valid 1 edge after the inputs.
- Latency with a memory access: stall is high for 1+ACCESS_CYCLES cycles (5 with the default), low in DONE, and the outputs update on the edge that ends DONE. The instruction therefore occupies MEM for ACCESS_CYCLES+2 cycles.
- A request present in the cycle after DONE (the next instruction) starts a new access immediately; there is no dead cycle beyond the IDLE cycle.
- ACCESS_CYCLES=1: a single BUSY cycle performs the access and is followed by DONE.
- rst mid-access returns to IDLE immediately:
  - A store whose final BUSY edge has not occurred is not committed.
  - A store already committed (state DONE) remains in memory.
  - stall drops while rst is high.
- A load in the DONE cycle observes any store committed by the preceding instruction (read-after-write through memory is exact).

## Test plan
- Reset: assert rst mid-run → all outputs 0, stall=0; after release, an ALU instruction (wb_en_in=1, alu_result=0x55, dest=3) appears on the outputs 1 edge later with stall never high.
- Store/load: store st_val=0xDEADBEEF to address 1032, then load from 1032 → each instruction holds stall high for exactly 5 cycles; the load outputs mem_data_out=0xDEADBEEF, mem_r_en_out=1, and wb_en_out=1 for exactly 1 cycle.
- Aliasing: store 0x12345678 to address 1024+256 (DEPTH=64), then load from 1024 → 0x12345678. Load from 1026 → same word (offset ignored).
- Reset mid-store: the store is cut by rst in the 3rd BUSY cycle, then a load from the same address → the old value (0 from power-up), not the store data.
- Both enables: mem_r_en=mem_w_en=1, st_val=0xA5A5A5A5 at 1040 → mem_data_out=0 and the memory is written; a subsequent load from 1040 returns 0xA5A5A5A5.
- Back-to-back: ALU, store, ALU, load → bubbles appear only during stalls, the WB output sequence is ALU, store, ALU, load, and no output is duplicated.
